fusion_tensor_assembler: RTL and testbench

Collects one 32-element feature vector from each of the camera, LiDAR and radar feature extractors and assembles them into the 1536-bit, 96-element raw tensor consumed by the fusion compressor. It sits directly upstream of the compressor. Each sensor has its own valid/ready stream and its own holding slot. A frame is emitted when all three slots are full. If a frame is still incomplete after a timeout, it is emitted with the missing slots zero-filled and flagged.

---
 rtl/fusion_tensor_assembler.sv | 144 ++++++++++++++
 tb/tb_fusion_tensor_assembler.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_tensor_assembler.sv
// Purpose : gathers one feature vector each from camera, LiDAR and radar and
//           emits a 96-element raw tensor when all three slots are full, or a
//           zero-filled, flagged partial frame once TIMEOUT_CYCLES have passed.
// Ports   : clk/rst_n (async active-low); per-sensor <sensor>_data/_valid/_ready
//           streams; raw_tensor + tensor_valid pulse + sensor_mask toward the
//           compressor; frame_count (wraps) and partial_count (saturates).
module fusion_tensor_assembler #(
  parameter int BIT_WIDTH        = 16,
  parameter int ELEMS_PER_SENSOR = 32,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [ELEMS_PER_SENSOR*BIT_WIDTH-1:0]     cam_data,
  input  logic                                      cam_valid,
  output logic                                      cam_ready,
  input  logic [ELEMS_PER_SENSOR*BIT_WIDTH-1:0]     lidar_data,
  input  logic                                      lidar_valid,
  output logic                                      lidar_ready,
  input  logic [ELEMS_PER_SENSOR*BIT_WIDTH-1:0]     radar_data,
  input  logic                                      radar_valid,
  output logic                                      radar_ready,
  output logic [3*ELEMS_PER_SENSOR*BIT_WIDTH-1:0]   raw_tensor,
  output logic                                      tensor_valid,
  output logic [2:0]                                sensor_mask,
  output logic [15:0]                               frame_count,
  output logic [15:0]                               partial_count
);

  localparam int          SLOT_W      = ELEMS_PER_SENSOR * BIT_WIDTH;
  localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [15:0]       timer, timer_next;
  logic [SLOT_W-1:0] cam_slot, lidar_slot, radar_slot;
  logic [2:0]        full;        // {radar, lidar, cam}
  logic [2:0]        valid_vec;
  logic [2:0]        xfer;
  logic              all_full;
  logic              timeout_hit;
  logic              emit_now;

  assign valid_vec   = {radar_valid, lidar_valid, cam_valid};
  assign all_full    = &full;
  assign timeout_hit = (state == COLLECT) && (timer == TIMER_LIMIT);
  // A complete frame on the limit cycle is still a complete emit: the mask
  // captured below is 3'b111, so partial_count is left alone.
  assign emit_now    = all_full || timeout_hit;

  // Ready depends only on registered flags/timer, never on any valid input.
  // Holding ready low while emitting keeps late arrivals out of the frame
  // being flushed; they land in the following frame instead.
  assign cam_ready   = !full[0] && !emit_now;
  assign lidar_ready = !full[1] && !emit_now;
  assign radar_ready = !full[2] && !emit_now;

  assign xfer = valid_vec & {radar_ready, lidar_ready, cam_ready};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= 16'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      IDLE: begin
        timer_next = 16'd0;
        if (|xfer) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (emit_now) begin
          state_next = IDLE;
          timer_next = 16'd0;
        end else begin
          timer_next = timer + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = 16'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------- slots
  // xfer is always zero while emit_now is high, so clearing and loading
  // never compete on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= 3'b000;
      cam_slot   <= '0;
      lidar_slot <= '0;
      radar_slot <= '0;
    end else if (emit_now) begin
      full <= 3'b000;
    end else begin
      full <= full | xfer;
      if (xfer[0]) cam_slot   <= cam_data;
      if (xfer[1]) lidar_slot <= lidar_data;
      if (xfer[2]) radar_slot <= radar_data;
    end
  end

  // ---------------------------------------------------------------- output
  // raw_tensor and sensor_mask only change on an emit edge, so the
  // compressor sees stable values between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_tensor    <= '0;
      tensor_valid  <= 1'b0;
      sensor_mask   <= 3'b000;
      frame_count   <= 16'd0;
      partial_count <= 16'd0;
    end else begin
      tensor_valid <= emit_now;
      if (emit_now) begin
        raw_tensor  <= {full[2] ? radar_slot : {SLOT_W{1'b0}},
                        full[1] ? lidar_slot : {SLOT_W{1'b0}},
                        full[0] ? cam_slot   : {SLOT_W{1'b0}}};
        sensor_mask <= full;
        frame_count <= frame_count + 16'd1;
        if (!all_full && (partial_count != 16'hFFFF)) begin
          partial_count <= partial_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fusion_tensor_assembler.sv
// Bench for fusion_tensor_assembler: directed scenarios plus a randomized run,
// all compared against a frame-level reference model kept in this file.
module tb_fusion_tensor_assembler;

  localparam int BW  = 16;
  localparam int EPS = 32;
  localparam int SW  = BW * EPS;
  localparam int TW  = 3 * SW;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] cam_data = '0, lidar_data = '0, radar_data = '0;
  logic          cam_valid = 1'b0, lidar_valid = 1'b0, radar_valid = 1'b0;
  logic          cam_ready, lidar_ready, radar_ready;
  logic [TW-1:0] raw_tensor;
  logic          tensor_valid;
  logic [2:0]    sensor_mask;
  logic [15:0]   frame_count, partial_count;

  always #5 clk = ~clk;

  fusion_tensor_assembler #(
    .BIT_WIDTH(BW), .ELEMS_PER_SENSOR(EPS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cam_data(cam_data), .cam_valid(cam_valid), .cam_ready(cam_ready),
    .lidar_data(lidar_data), .lidar_valid(lidar_valid), .lidar_ready(lidar_ready),
    .radar_data(radar_data), .radar_valid(radar_valid), .radar_ready(radar_ready),
    .raw_tensor(raw_tensor), .tensor_valid(tensor_valid), .sensor_mask(sensor_mask),
    .frame_count(frame_count), .partial_count(partial_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (frame level)
  logic [SW-1:0] m_slot [3];
  logic [2:0]    m_full;
  int            m_first;     // edge index of the first vector of the open frame
  int            cyc = 0;     // edges seen since bench start
  logic [TW-1:0] m_raw;
  logic [2:0]    m_mask;
  logic [15:0]   m_frames, m_partials;
  logic          m_tv;
  logic [2:0]    m_acc;       // sensors accepted on the last edge

  // ---------------- stimulus queues, one per sensor
  logic [SW-1:0] q_cam[$], q_lidar[$], q_radar[$];
  logic [2:0]    hold;

  function automatic logic [SW-1:0] pat(input logic [15:0] base);
    logic [SW-1:0] v;
    for (int i = 0; i < EPS; i++) v[i*BW +: BW] = base + 16'(i);
    return v;
  endfunction

  function automatic logic [SW-1:0] rnd_vec();
    logic [SW-1:0] v;
    for (int i = 0; i < SW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [SW-1:0] slot_or_zero(input int k);
    return m_full[k] ? m_slot[k] : {SW{1'b0}};
  endfunction

  // Ready expected for the coming edge: a slot takes data unless it is full or
  // a frame leaves on that edge (all full, or TO edges since the first vector).
  function automatic logic [2:0] exp_ready();
    logic emit_next;
    emit_next = (&m_full) || ((|m_full) && (cyc + 1 == m_first + TO));
    return emit_next ? 3'b000 : ~m_full;
  endfunction

  task automatic model_reset();
    m_full = 3'b000; m_raw = '0; m_mask = 3'b000;
    m_frames = 16'd0; m_partials = 16'd0; m_tv = 1'b0; m_acc = 3'b000;
    q_cam.delete(); q_lidar.delete(); q_radar.delete();
    hold = 3'b000;
  endtask

  // Advance one edge, update the model from the inputs present at that edge.
  task automatic step();
    logic [2:0]    v;
    logic [SW-1:0] d [3];
    logic          emit;
    @(posedge clk);
    v = {radar_valid, lidar_valid, cam_valid};
    d[0] = cam_data; d[1] = lidar_data; d[2] = radar_data;
    cyc++;
    emit = (&m_full) || ((|m_full) && (cyc == m_first + TO));
    m_acc = 3'b000;
    if (emit) begin
      m_raw  = {slot_or_zero(2), slot_or_zero(1), slot_or_zero(0)};
      m_mask = m_full;
      m_frames++;
      if (m_full != 3'b111 && m_partials != 16'hFFFF) m_partials++;
      m_tv   = 1'b1;
      m_full = 3'b000;
    end else begin
      m_tv  = 1'b0;
      m_acc = v & ~m_full;
      if (m_full == 3'b000 && m_acc != 3'b000) m_first = cyc;
      for (int k = 0; k < 3; k++) if (m_acc[k]) m_slot[k] = d[k];
      m_full = m_full | m_acc;
    end
    #1;
  endtask

  // Present queue heads as valid data (unless held), take one edge, pop accepted.
  task automatic drive_cycle();
    cam_valid   = (q_cam.size() > 0)   && !hold[0];
    lidar_valid = (q_lidar.size() > 0) && !hold[1];
    radar_valid = (q_radar.size() > 0) && !hold[2];
    cam_data    = (q_cam.size() > 0)   ? q_cam[0]   : '0;
    lidar_data  = (q_lidar.size() > 0) ? q_lidar[0] : '0;
    radar_data  = (q_radar.size() > 0) ? q_radar[0] : '0;
    step();
    if (m_acc[0]) void'(q_cam.pop_front());
    if (m_acc[1]) void'(q_lidar.pop_front());
    if (m_acc[2]) void'(q_radar.pop_front());
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
        !== {3'b111, 1'b0, 3'b000, 16'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_ctrl: got %h want %h",
        {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
        {3'b111, 1'b0, 3'b000, 16'd0, 16'd0});
    end
    n_vec++;
    if (raw_tensor !== {TW{1'b0}}) begin
      n_err++; $display("FAIL reset_raw: got nonzero raw_tensor, want 0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    int tv_n = 0, tv_at = -1, radar_at = -1;
    q_cam.push_back(pat(16'h0100));
    q_lidar.push_back(pat(16'h0200));
    q_radar.push_back(pat(16'h0300));
    for (int c = 0; c < 10; c++) begin
      hold = {c < 5, c < 3, c < 1};
      drive_cycle();
      if (m_acc[2]) radar_at = c;
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL seq_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      n_vec++;
      if (raw_tensor !== m_raw) begin
        n_err++; $display("FAIL seq_raw c%0d: got %h want %h", c, raw_tensor, m_raw);
      end
      if (tensor_valid === 1'b1) begin
        tv_n++; tv_at = c;
        n_vec++;
        if ({raw_tensor[15:0], raw_tensor[527:512], raw_tensor[1535:1520], sensor_mask, frame_count, partial_count}
            !== {16'h0100, 16'h0200, 16'h031F, 3'b111, 16'd1, 16'd0}) begin
          n_err++;
          $display("FAIL seq_fields: got %h %h %h mask %b fc %0d pc %0d", raw_tensor[15:0],
            raw_tensor[527:512], raw_tensor[1535:1520], sensor_mask, frame_count, partial_count);
        end
      end
    end
    n_vec++;
    if (tv_n !== 1 || tv_at !== radar_at + 1) begin
      n_err++; $display("FAIL seq_latency: got %0d pulses at %0d, want 1 at %0d", tv_n, tv_at, radar_at + 1);
    end
  endtask

  task automatic test_simultaneous();
    int zero_rdy = 0;
    q_cam.push_back(rnd_vec()); q_lidar.push_back(rnd_vec()); q_radar.push_back(rnd_vec());
    hold = 3'b000;
    for (int c = 0; c < 4; c++) begin
      drive_cycle();
      if ({radar_ready, lidar_ready, cam_ready} === 3'b000) zero_rdy++;
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL simul_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      n_vec++;
      if (raw_tensor !== m_raw) begin
        n_err++; $display("FAIL simul_raw c%0d: got %h want %h", c, raw_tensor, m_raw);
      end
      if (c == 1) begin
        n_vec++;
        if (tensor_valid !== 1'b1 || sensor_mask !== 3'b111) begin
          n_err++; $display("FAIL simul_emit: got tv %b mask %b want 1 111", tensor_valid, sensor_mask);
        end
      end
    end
    n_vec++;
    if (zero_rdy !== 1) begin
      n_err++; $display("FAIL simul_ready_gap: got %0d cycles, want 1", zero_rdy);
    end
  endtask

  task automatic test_timeout();
    int acc_at = -1, tv_at = -1;
    logic [15:0] pc0;
    pc0 = partial_count;
    q_cam.push_back(pat(16'h0A00));
    hold = 3'b000;
    for (int c = 0; c < 12; c++) begin
      drive_cycle();
      if (m_acc[0]) acc_at = c;
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL tmo_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      n_vec++;
      if (raw_tensor !== m_raw) begin
        n_err++; $display("FAIL tmo_raw c%0d: got %h want %h", c, raw_tensor, m_raw);
      end
      if (tensor_valid === 1'b1) begin
        tv_at = c;
        n_vec++;
        if (raw_tensor[1535:512] !== {1024{1'b0}} || raw_tensor[511:0] !== pat(16'h0A00)
            || sensor_mask !== 3'b001 || partial_count !== pc0 + 16'd1) begin
          n_err++;
          $display("FAIL tmo_frame: mask %b pc %0d want 001 %0d (upper zero %b)", sensor_mask,
            partial_count, pc0 + 16'd1, raw_tensor[1535:512] === {1024{1'b0}});
        end
      end
    end
    n_vec++;
    if (tv_at - acc_at !== TO) begin
      n_err++; $display("FAIL tmo_latency: got %0d want %0d", tv_at - acc_at, TO);
    end
  endtask

  task automatic test_repeat();
    logic [SW-1:0] va, vb, ve;
    int frames = 0;
    va = rnd_vec(); vb = rnd_vec(); ve = rnd_vec();
    q_cam.push_back(va); q_cam.push_back(vb);
    q_lidar.push_back(rnd_vec()); q_lidar.push_back(ve);
    q_radar.push_back(rnd_vec()); q_radar.push_back(rnd_vec());
    for (int c = 0; c < 10; c++) begin
      hold = {c < 4, c < 3, 1'b0};
      drive_cycle();
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL rep_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      n_vec++;
      if (raw_tensor !== m_raw) begin
        n_err++; $display("FAIL rep_raw c%0d: got %h want %h", c, raw_tensor, m_raw);
      end
      if (c <= 3) begin
        n_vec++;
        if (cam_ready !== 1'b0) begin
          n_err++; $display("FAIL rep_cam_ready c%0d: got %b want 0", c, cam_ready);
        end
      end
      if (tensor_valid === 1'b1) begin
        frames++;
        n_vec++;
        if (frames == 1 && raw_tensor[511:0] !== va) begin
          n_err++; $display("FAIL rep_frame1_cam: got %h want %h", raw_tensor[511:0], va);
        end
        if (frames == 2) begin
          n_vec++;
          if (raw_tensor[511:0] !== vb || raw_tensor[1023:512] !== ve || sensor_mask !== 3'b111) begin
            n_err++; $display("FAIL rep_frame2: cam %h want %h mask %b", raw_tensor[511:0], vb, sensor_mask);
          end
        end
      end
    end
    n_vec++;
    if (frames !== 2) begin
      n_err++; $display("FAIL rep_frames: got %0d want 2", frames);
    end
  endtask

  task automatic test_late_sensor();
    logic [SW-1:0] vr;
    int frames = 0;
    logic refilled = 1'b0;
    vr = rnd_vec();
    q_cam.push_back(rnd_vec()); q_lidar.push_back(rnd_vec()); q_radar.push_back(vr);
    for (int c = 0; c < 20; c++) begin
      hold = {c < TO, c < 2, 1'b0};
      drive_cycle();
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL late_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      n_vec++;
      if (raw_tensor !== m_raw) begin
        n_err++; $display("FAIL late_raw c%0d: got %h want %h", c, raw_tensor, m_raw);
      end
      if (tensor_valid === 1'b1) begin
        frames++;
        n_vec++;
        if (frames == 1 && (sensor_mask !== 3'b011 || raw_tensor[1535:1024] !== {SW{1'b0}})) begin
          n_err++; $display("FAIL late_frame1: mask %b want 011", sensor_mask);
        end
        if (frames == 2 && (sensor_mask !== 3'b111 || raw_tensor[1535:1024] !== vr)) begin
          n_err++; $display("FAIL late_frame2: mask %b radar %h want 111 %h", sensor_mask, raw_tensor[1535:1024], vr);
        end
        if (!refilled) begin
          q_cam.push_back(rnd_vec()); q_lidar.push_back(rnd_vec()); refilled = 1'b1;
        end
      end
    end
    n_vec++;
    if (frames !== 2) begin
      n_err++; $display("FAIL late_frames: got %0d want 2", frames);
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] p0, p1, p2;
    int frames = 0;
    q_cam.push_back(rnd_vec()); q_lidar.push_back(rnd_vec());
    hold = 3'b000;
    for (int c = 0; c < 3; c++) drive_cycle();
    cam_valid = 1'b0; lidar_valid = 1'b0; radar_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
        !== {3'b111, 1'b0, 3'b000, 16'd0, 16'd0} || raw_tensor !== {TW{1'b0}}) begin
      n_err++;
      $display("FAIL rstmid_async: got %h want %h", {radar_ready, lidar_ready, cam_ready, tensor_valid,
        sensor_mask, frame_count, partial_count}, {3'b111, 1'b0, 3'b000, 16'd0, 16'd0});
    end
    @(posedge clk); #1;
    n_vec++;
    if (tensor_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_tv: got %b want 0", tensor_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    p0 = rnd_vec(); p1 = rnd_vec(); p2 = rnd_vec();
    q_cam.push_back(p0); q_lidar.push_back(p1); q_radar.push_back(p2);
    for (int c = 0; c < 6; c++) begin
      hold = {c < 2, c < 1, 1'b0};
      drive_cycle();
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL rstmid_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      if (tensor_valid === 1'b1) begin
        frames++;
        n_vec++;
        if (raw_tensor !== {p2, p1, p0} || frame_count !== 16'd1) begin
          n_err++; $display("FAIL rstmid_frame: fc %0d want 1, raw %h", frame_count, raw_tensor);
        end
      end
    end
    n_vec++;
    if (frames !== 1) begin
      n_err++; $display("FAIL rstmid_frames: got %0d want 1", frames);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (q_cam.size() == 0   && $urandom_range(0, 3) == 0) q_cam.push_back(rnd_vec());
      if (q_lidar.size() == 0 && $urandom_range(0, 3) == 0) q_lidar.push_back(rnd_vec());
      if (q_radar.size() == 0 && $urandom_range(0, 5) == 0) q_radar.push_back(rnd_vec());
      hold = {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0};
      drive_cycle();
      n_vec++;
      if ({radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count}
          !== {exp_ready(), m_tv, m_mask, m_frames, m_partials}) begin
        n_err++;
        $display("FAIL rand_ctrl c%0d: got %h want %h", c,
          {radar_ready, lidar_ready, cam_ready, tensor_valid, sensor_mask, frame_count, partial_count},
          {exp_ready(), m_tv, m_mask, m_frames, m_partials});
      end
      n_vec++;
      if (raw_tensor !== m_raw) begin
        n_err++; $display("FAIL rand_raw c%0d: got %h want %h", c, raw_tensor, m_raw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_simultaneous();
    test_timeout();
    test_repeat();
    test_late_sensor();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
